multiplier32_fp: RTL and testbench
==================================

Name: multiplier32_fp

Overview:
- Multi-cycle IEEE-754 single-precision floating-point multiplier with a start/done handshake.
- Computes a_i × b_i with round-to-nearest-even.
- Flushes subnormals to zero and raises NaN, infinity, overflow and underflow status flags.
- Used as a standalone arithmetic unit by a controller that pulses start_i and waits for done_o.

Parameters:
- None. Format is fixed: 1 sign bit, 8-bit exponent with bias 127, 23-bit fraction.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-high despite its name
- start_i  in  1  single-cycle request; operands sampled on the same edge
- a_i  in  32  operand A, IEEE-754 single precision
- b_i  in  32  operand B, IEEE-754 single precision
- product_o  out  32  result; held stable from done_o until the next result
- done_o  out  1  one-cycle pulse when product_o and the flags are valid
- nan_o  out  1  result is NaN
- infinit_o  out  1  result is ±infinity (operand infinity or overflow)
- overflow_o  out  1  finite operands, result magnitude too large
- underflow_o  out  1  nonzero result flushed to zero (includes subnormal operands)

Behaviour:
- Reset: clk edge with rst_n=1 forces state IDLE and clears all outputs to 0. This applies from any state; an in-flight operation is discarded with no done_o.
- FSM states: IDLE → UNPACK → MULT → NORM → ROUND → DONE → IDLE.
- IDLE: when start_i=1, register a_i and b_i, go to UNPACK.
- start_i is ignored in all states other than IDLE.
- Fixed latency for every operand class: done_o goes high on the 5th rising edge after the edge that sampled start_i, and lasts exactly 1 cycle.
- product_o and all four flags update only on entry to DONE, then hold until the next DONE or reset.
- UNPACK:
  - Extract sign = sa XOR sb.
  - Classify each operand: zero (exp=0, including subnormals, flushed to zero), inf (exp=255, frac=0), NaN (exp=255, frac≠0), normal.
  - Normal mantissa = {1, frac}, 24 bits.
- MULT: 24×24 → 48-bit product; exponent sum = ea + eb − 127, kept signed and at least 10 bits wide.
- NORM: if product bit 47 = 1, shift right by 1 and increment the exponent. Keep 23 fraction bits plus guard, round and sticky bits.
- ROUND: round-to-nearest-even. A mantissa carry-out renormalises and increments the exponent.
- Special-case priority, highest first:
  1. Either operand NaN, or inf × zero → 0x7FC00000, nan_o=1.
  2. Either operand inf → {sign, 0x7F800000}, infinit_o=1.
  3. Either operand zero or subnormal → {sign, 31'h0}. underflow_o=1 only if a subnormal operand was flushed.
  4. Final exponent ≥ 255 → {sign, 0x7F800000}, overflow_o=1, infinit_o=1.
  5. Final exponent ≤ 0 → {sign, 31'h0}, underflow_o=1 (no subnormal outputs).
  6. Otherwise → {sign, exp[7:0], frac23}, all flags 0.
- At most one of nan_o, overflow_o or underflow_o is set. infinit_o may accompany overflow_o.
- Back-to-back operation: start_i may be reasserted in the cycle after done_o (IDLE).

Test Plan:
- Reset held 1 cycle, then released → all outputs 0, done_o stays 0 with no start.
- a=25.0 (0x41C80000), b=10.0 (0x41200000) → product 0x437A0000 (250.0), flags 0, done_o exactly 5 edges after start. Also 3.02 × 4.0 → 0x414147AE.
- a=−1.5 (0xBFC00000), b=2.0 → 0xC0400000. Also 0.0 × 2.0 → 0x00000000, flags 0.
- a=1.0, b=0x7F800001 → 0x7FC00000, nan_o=1. Also 0x7F800000 × 0 → 0x7FC00000, nan_o=1.
- 0x7F800000 × 1.0 → 0x7F800000, infinit_o=1. Also 0xFF800000 × 1.0 → 0xFF800000, infinit_o=1.
- 0x00000001 × 0x00000001 → 0x00000000, underflow_o=1.
- 0x7F7FFFFF × 0x7F7FFFFF → 0x7F800000, overflow_o=1, infinit_o=1.
- Reset asserted during MULT → no done_o, outputs 0; next start completes normally.

Source files
------------

// File: rtl/multiplier32_fp.sv
// multiplier32_fp: multi-cycle IEEE-754 single-precision multiplier.
// Round-to-nearest-even, subnormal operands flushed to zero, no subnormal
// results. One operation in flight; start_i is only accepted in IDLE.
// Results and flags are registered on entry to DONE; done_o pulses one
// cycle later, five edges after the edge that sampled start_i.
module multiplier32_fp (
    input  logic        clk,
    input  logic        rst_n,        // synchronous, active-high
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] product_o,
    output logic        done_o,
    output logic        nan_o,
    output logic        infinit_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Captured operands
    logic [31:0] a_q, b_q;

    // Unpacked fields and operand classification (either operand)
    logic        sign_q;
    logic        is_nan_q, is_inf_q, is_zero_q, is_sub_q;
    logic [23:0] ma_q, mb_q;
    logic [7:0]  ea_q, eb_q;

    // Datapath pipeline registers
    logic [47:0]        prod_q;
    logic signed [10:0] exp_q;       // biased exponent, signed to catch under/overflow
    logic [22:0]        frac_q;
    logic               grd_q;       // first bit below the kept fraction
    logic               stk_q;       // OR of every bit below the guard bit

    // Registered results
    logic [31:0] product_q;
    logic        done_q, nan_q, inf_q, ovf_q, unf_q;

    // Combinational operand decode
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_sub, b_sub, a_inf, b_inf, a_nan, b_nan;

    // Combinational rounding / final selection
    logic               round_up;
    logic [23:0]        frac_sum;    // {carry, fraction}
    logic signed [10:0] exp_r;
    logic [31:0]        product_d;
    logic               nan_d, inf_d, ovf_d, unf_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: fixed walk through the pipeline stages
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = UNPACK;
            UNPACK:  state_d = MULT;
            MULT:    state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand field extraction and classification
    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_sub  = a_zero && (fa != 23'd0);
        b_sub  = b_zero && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    end

    // Datapath: each stage register loads only in its own state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sign_q    <= 1'b0;
            is_nan_q  <= 1'b0;
            is_inf_q  <= 1'b0;
            is_zero_q <= 1'b0;
            is_sub_q  <= 1'b0;
            ma_q      <= 24'd0;
            mb_q      <= 24'd0;
            ea_q      <= 8'd0;
            eb_q      <= 8'd0;
            prod_q    <= 48'd0;
            exp_q     <= 11'sd0;
            frac_q    <= 23'd0;
            grd_q     <= 1'b0;
            stk_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q <= a_i;
                        b_q <= b_i;
                    end
                end
                UNPACK: begin
                    sign_q    <= a_q[31] ^ b_q[31];
                    is_nan_q  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
                    is_inf_q  <= a_inf || b_inf;
                    is_zero_q <= a_zero || b_zero;
                    is_sub_q  <= a_sub || b_sub;
                    ma_q      <= {1'b1, fa};
                    mb_q      <= {1'b1, fb};
                    ea_q      <= ea;
                    eb_q      <= eb;
                end
                MULT: begin
                    prod_q <= {24'd0, ma_q} * {24'd0, mb_q};
                    exp_q  <= signed'({3'b000, ea_q}) + signed'({3'b000, eb_q}) - 11'sd127;
                end
                NORM: begin
                    // Product of two [1,2) mantissas lies in [1,4)
                    if (prod_q[47]) begin
                        frac_q <= prod_q[46:24];
                        grd_q  <= prod_q[23];
                        stk_q  <= |prod_q[22:0];
                        exp_q  <= exp_q + 11'sd1;
                    end else begin
                        frac_q <= prod_q[45:23];
                        grd_q  <= prod_q[22];
                        stk_q  <= |prod_q[21:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Rounding and special-case priority for the final result
    always_comb begin
        round_up  = grd_q && (stk_q || frac_q[0]);
        frac_sum  = {1'b0, frac_q} + {23'd0, round_up};
        // On carry-out the fraction wraps to zero, which is the renormalised 1.0
        exp_r     = exp_q + (frac_sum[23] ? 11'sd1 : 11'sd0);
        product_d = {sign_q, exp_r[7:0], frac_sum[22:0]};
        nan_d     = 1'b0;
        inf_d     = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (is_nan_q) begin
            product_d = 32'h7FC0_0000;
            nan_d     = 1'b1;
        end else if (is_inf_q) begin
            product_d = {sign_q, 31'h7F80_0000};
            inf_d     = 1'b1;
        end else if (is_zero_q) begin
            product_d = {sign_q, 31'h0};
            unf_d     = is_sub_q;
        end else if (exp_r >= 11'sd255) begin
            product_d = {sign_q, 31'h7F80_0000};
            ovf_d     = 1'b1;
            inf_d     = 1'b1;
        end else if (exp_r <= 11'sd0) begin
            product_d = {sign_q, 31'h0};
            unf_d     = 1'b1;
        end
    end

    // Output registers: results load on entry to DONE, done pulses on leaving it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            product_q <= 32'd0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == ROUND) begin
                product_q <= product_d;
                nan_q     <= nan_d;
                inf_q     <= inf_d;
                ovf_q     <= ovf_d;
                unf_q     <= unf_d;
            end
        end
    end

    assign product_o   = product_q;
    assign done_o      = done_q;
    assign nan_o       = nan_q;
    assign infinit_o   = inf_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_multiplier32_fp.sv
// Self-checking bench for multiplier32_fp: directed table, randomized
// operands against an arithmetic reference model, and reset corner cases.
module tb_multiplier32_fp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] a_i, b_i;
    logic [31:0] product_o;
    logic        done_o, nan_o, infinit_o, overflow_o, underflow_o;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;   // {nan, inf, overflow, underflow}
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    multiplier32_fp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .product_o   (product_o),
        .done_o      (done_o),
        .nan_o       (nan_o),
        .infinit_o   (infinit_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference model: exact integer product, rounded to nearest-even by arithmetic
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p, output logic [3:0] f);
        logic        sg;
        int          ea, eb, e, s;
        logic [22:0] fa, fb;
        logic [63:0] m, keep, rem, half;
        bit a_z, b_z, a_s, b_s, a_i_, b_i_, a_n, b_n;
        sg   = a[31] ^ b[31];
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        fa   = a[22:0];
        fb   = b[22:0];
        a_z  = (ea == 0);
        b_z  = (eb == 0);
        a_s  = a_z && (fa != 0);
        b_s  = b_z && (fb != 0);
        a_i_ = (ea == 255) && (fa == 0);
        b_i_ = (eb == 255) && (fb == 0);
        a_n  = (ea == 255) && (fa != 0);
        b_n  = (eb == 255) && (fb != 0);
        f = 4'b0000;
        if (a_n || b_n || (a_i_ && b_z) || (b_i_ && a_z)) begin
            p = 32'h7FC0_0000;
            f = 4'b1000;
        end else if (a_i_ || b_i_) begin
            p = {sg, 31'h7F80_0000};
            f = 4'b0100;
        end else if (a_z || b_z) begin
            p = {sg, 31'h0};
            f = (a_s || b_s) ? 4'b0001 : 4'b0000;
        end else begin
            m = {40'd0, 1'b1, fa} * {40'd0, 1'b1, fb};
            e = ea + eb - 127;
            if (m >= (64'd1 << 47)) begin
                s = 24;
                e = e + 1;
            end else begin
                s = 23;
            end
            keep = m >> s;
            rem  = m & ((64'd1 << s) - 64'd1);
            half = 64'd1 << (s - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
            if (keep == (64'd1 << 24)) begin
                keep = keep >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                p = {sg, 31'h7F80_0000};
                f = 4'b0110;
            end else if (e <= 0) begin
                p = {sg, 31'h0};
                f = 4'b0001;
            end else begin
                p = {sg, e[7:0], keep[22:0]};
            end
        end
    endtask

    // One transaction: pulse start, count edges to done, check pulse width
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p, output logic [3:0] f,
                         output int lat, output logic done_after);
        @(negedge clk);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = $urandom;   // operands must already be captured
        b_i     = $urandom;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        p = product_o;
        f = {nan_o, infinit_o, overflow_o, underflow_o};
        @(posedge clk);
        #1;
        done_after = done_o;
        $display("op a=%h b=%h -> p=%h flags=%b latency=%0d", a, b, p, f, lat);
    endtask

    // Check one full transaction against the model
    task automatic run_and_check(input string nm, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p, ep;
        logic [3:0]  f, ef;
        int          lat;
        logic        da;
        model(a, b, ep, ef);
        do_op(a, b, p, f, lat, da);
        chk({nm, " product"}, p, ep);
        chk({nm, " flags"}, {28'd0, f}, {28'd0, ef});
        chk({nm, " latency"}, lat, 5);
        chk({nm, " done width"}, {31'd0, da}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       ;                                                  // any pattern
            1:       r[30:23] = 8'd0;                                   // zero / subnormal
            2:       r[30:23] = 8'd255;                                 // inf / NaN
            3:       r[30:23] = 8'($urandom_range(190, 254));           // overflow region
            4:       r[30:23] = 8'($urandom_range(1, 70));              // underflow region
            5:       begin r[30:23] = 8'($urandom_range(110, 140)); r[22:0] = 23'h7FFFFF; end
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] p;
        logic [3:0]  f;
        int          lat, seen;
        logic        da;

        tbl[0]  = '{32'h41C80000, 32'h41200000, 32'h437A0000, 4'b0000};
        tbl[1]  = '{32'h404147AE, 32'h40800000, 32'h414147AE, 4'b0000};
        tbl[2]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000};
        tbl[3]  = '{32'h00000000, 32'h40000000, 32'h00000000, 4'b0000};
        tbl[4]  = '{32'h3F800000, 32'h7F800001, 32'h7FC00000, 4'b1000};
        tbl[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        tbl[6]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0100};
        tbl[7]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0100};
        tbl[8]  = '{32'h00000001, 32'h00000001, 32'h00000000, 4'b0001};
        tbl[9]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0110};
        tbl[10] = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0001};

        rst_n   = 1'b1;
        start_i = 1'b0;
        a_i     = 32'd0;
        b_i     = 32'd0;

        // Reset for one edge, then idle with no start
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        chk("reset product", product_o, 32'd0);
        chk("reset flags", {27'd0, done_o, nan_o, infinit_o, overflow_o, underflow_o}, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        chk("idle no done", seen, 0);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].a, tbl[i].b, p, f, lat, da);
            chk($sformatf("tbl%0d product", i), p, tbl[i].p);
            chk($sformatf("tbl%0d flags", i), {28'd0, f}, {28'd0, tbl[i].f});
            chk($sformatf("tbl%0d latency", i), lat, 5);
            chk($sformatf("tbl%0d done width", i), {31'd0, da}, 32'd0);
        end

        // Randomized against the reference model
        for (int i = 0; i < 150; i++) begin
            run_and_check($sformatf("rnd%0d", i), rnd_op(), rnd_op());
        end

        // Reset while in MULT: leave nonzero outputs first, then abort
        run_and_check("pre-abort", 32'h7F7FFFFF, 32'h7F7FFFFF);
        @(negedge clk);
        start_i = 1'b1;
        a_i     = 32'h41C80000;
        b_i     = 32'h41200000;
        @(posedge clk);              // sampled, now UNPACK
        #1;
        start_i = 1'b0;
        @(posedge clk);              // now MULT
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("abort product", product_o, 32'd0);
        chk("abort flags", {27'd0, done_o, nan_o, infinit_o, overflow_o, underflow_o}, 32'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        chk("abort no done", seen, 0);
        run_and_check("post-abort", 32'h41C80000, 32'h41200000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
